// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-level controller for the pattern generators.
// Selects the active pattern and drives the shared animation strobes.
// A pattern switch comes from a debounced button press or from the
// auto-cycle dwell timer. Each switch blanks the screen for a few frames.
module pattern_sequencer #(
    parameter int NUM_PATTERNS    = 4,
    parameter int DWELL_FRAMES    = 600,
    parameter int BLANK_FRAMES    = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic [1:0] speed,
    output logic [2:0] pattern_sel,
    output logic       next_frame,
    output logic [2:0] step_size,
    output logic       blank,
    output logic       pattern_rst
);

    localparam logic [9:0]  DWELL_LAST = 10'(DWELL_FRAMES - 1);
    localparam logic [3:0]  BLANK_LAST = 4'(BLANK_FRAMES - 1);
    localparam logic [17:0] DEB_LAST   = 18'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]  SEL_LAST   = 3'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {S_RUN, S_BLANK, S_SWITCH} state_t;

    state_t      state, state_d;
    logic        btn_s1, btn_s2, btn_db, btn_db_q;
    logic [17:0] deb_cnt;
    logic        btn_press;
    logic [9:0]  dwell, dwell_d;
    logic [3:0]  blank_cnt, blank_cnt_d;
    logic [2:0]  sel_d;
    logic        next_frame_d, blank_d, pattern_rst_d;

    // Synchronize the raw button and accept a new level only after it has held steady
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_s1   <= btn_next;
            btn_s2   <= btn_s1;
            btn_db_q <= btn_db;
            if (btn_s2 == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 18'd1;
            end
        end
    end

    // Only the rising edge of the debounced level is an event; release is silent
    assign btn_press = btn_db & ~btn_db_q;

    // Step size is latched at frame_start so it never changes mid-frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_size <= 3'd1;
        end else if (frame_start) begin
            case (speed)
                2'd0:    step_size <= 3'd1;
                2'd1:    step_size <= 3'd2;
                2'd2:    step_size <= 3'd4;
                default: step_size <= 3'd7;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_d;
    end

    // Next-state: a press and a dwell expiry in the same cycle collapse into one switch
    always_comb begin
        state_d = state;
        case (state)
            S_RUN: begin
                if (btn_press || (frame_start && auto_en && dwell == DWELL_LAST))
                    state_d = S_BLANK;
            end
            S_BLANK: begin
                if (frame_start && blank_cnt == BLANK_LAST)
                    state_d = S_SWITCH;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Next values of the registered outputs and frame counters
    always_comb begin
        next_frame_d  = 1'b0;
        blank_d       = blank;
        pattern_rst_d = 1'b0;
        sel_d         = pattern_sel;
        dwell_d       = dwell;
        blank_cnt_d   = blank_cnt;
        case (state)
            S_RUN: begin
                next_frame_d = frame_start;
                if (!auto_en)
                    dwell_d = '0;
                else if (frame_start && dwell != DWELL_LAST)
                    dwell_d = dwell + 10'd1;
                if (state_d == S_BLANK) begin
                    blank_d     = 1'b1;
                    blank_cnt_d = '0;
                end
            end
            S_BLANK: begin
                if (frame_start && blank_cnt != BLANK_LAST)
                    blank_cnt_d = blank_cnt + 4'd1;
            end
            default: begin
                // SWITCH: frame_start here is intentionally not forwarded
                sel_d         = (pattern_sel == SEL_LAST) ? 3'd0 : pattern_sel + 3'd1;
                pattern_rst_d = 1'b1;
                dwell_d       = '0;
                blank_d       = 1'b0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_sel <= 3'd0;
            next_frame  <= 1'b0;
            blank       <= 1'b0;
            pattern_rst <= 1'b0;
            dwell       <= '0;
            blank_cnt   <= '0;
        end else begin
            pattern_sel <= sel_d;
            next_frame  <= next_frame_d;
            blank       <= blank_d;
            pattern_rst <= pattern_rst_d;
            dwell       <= dwell_d;
            blank_cnt   <= blank_cnt_d;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with small parameters
// (3 patterns, 4 dwell frames, 2 blank frames, 8-cycle debounce, 50-cycle frames).
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst, frame_start, btn_next, auto_en;
    logic [1:0] speed;
    logic [2:0] pattern_sel, step_size;
    logic       next_frame, blank, pattern_rst;

    int   checks = 0;
    int   errors = 0;
    int   rst_pulses = 0;
    logic nf_seen;

    pattern_sequencer #(
        .NUM_PATTERNS(3), .DWELL_FRAMES(4), .BLANK_FRAMES(2), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .btn_next(btn_next),
        .auto_en(auto_en), .speed(speed), .pattern_sel(pattern_sel),
        .next_frame(next_frame), .step_size(step_size), .blank(blank),
        .pattern_rst(pattern_rst)
    );

    always #5 clk = ~clk;

    // Count pattern_rst cycles so multi-cycle or duplicate pulses show up
    initial forever begin
        @(negedge clk);
        if (pattern_rst === 1'b1) rst_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 50-cycle frame; frame_start is raised on the 49th negedge.
    // Button: solid high in [s0, s0+sl), toggling in [b0, b0+bl).
    // Afterwards next_frame is sampled one cycle after frame_start.
    task automatic frame(input int s0, input int sl, input int b0, input int bl);
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (i >= s0 && i < s0 + sl)      btn_next = 1'b1;
            else if (i >= b0 && i < b0 + bl) btn_next = (i % 2 == 1);
            else                             btn_next = 1'b0;
            if (i == 48) frame_start = 1'b1;
        end
        @(negedge clk);
        frame_start = 1'b0;
        nf_seen = next_frame;
    endtask

    // Four run frames, two frozen blank frames, then the switch lands
    task automatic auto_switch(input logic [2:0] exp_sel);
        for (int k = 1; k <= 4; k++) begin
            frame(0, 0, 0, 0);
            chk("blank_after_dwell", blank, (k == 4));
            chk("nf_in_run", nf_seen, 1);
        end
        for (int k = 1; k <= 2; k++) begin
            frame(0, 0, 0, 0);
            chk("nf_frozen", nf_seen, 0);
            chk("blank_held", blank, 1);
        end
        @(negedge clk);
        chk("sel_after_switch", pattern_sel, exp_sel);
        chk("blank_fall", blank, 0);
        chk("pattern_rst_pulse", pattern_rst, 1);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; btn_next = 1'b0; auto_en = 1'b0; speed = 2'd2;
        repeat (3) @(negedge clk);
        chk("rst_sel", pattern_sel, 0);
        chk("rst_nf", next_frame, 0);
        chk("rst_step", step_size, 1);
        chk("rst_blank", blank, 0);
        chk("rst_prst", pattern_rst, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("step_before_frame", step_size, 1);

        // 1: manual mode, animation runs, no switching
        for (int k = 0; k < 3; k++) begin
            frame(0, 0, 0, 0);
            chk("step_speed2", step_size, 4);
            chk("nf_delay", nf_seen, 1);
            chk("sel_manual", pattern_sel, 0);
            chk("blank_manual", blank, 0);
        end
        repeat (5) @(negedge clk);
        chk("nf_single_cycle", next_frame, 0);

        // 2/3: auto-cycle through three switches with wrap
        auto_en = 1'b1;
        auto_switch(3'd1);
        auto_switch(3'd2);
        auto_switch(3'd0);
        frame(0, 0, 0, 0);
        chk("prst_count_auto", rst_pulses, 3);

        // 4: short press rejected, long press switches, presses in blank ignored
        auto_en = 1'b0;
        frame(10, 5, 0, 0);
        chk("short_press_blank", blank, 0);
        chk("short_press_sel", pattern_sel, 0);
        frame(2, 12, 30, 12);
        chk("long_press_blank", blank, 1);
        chk("long_press_nf", nf_seen, 0);
        frame(5, 20, 0, 0);
        chk("blank_press_held", blank, 1);
        @(negedge clk);
        chk("btn_switch_sel", pattern_sel, 1);
        chk("btn_switch_prst", pattern_rst, 1);
        frame(0, 0, 0, 0);
        chk("no_second_switch", blank, 0);
        chk("sel_after_btn", pattern_sel, 1);
        chk("nf_resumed", nf_seen, 1);
        chk("prst_count_btn", rst_pulses, 4);

        // 5: press lands in the same cycle as dwell expiry
        auto_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            frame(0, 0, 0, 0);
            chk("coinc_pre_blank", blank, 0);
        end
        frame(38, 10, 0, 0);
        chk("coinc_blank", blank, 1);
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        @(negedge clk);
        chk("coinc_sel", pattern_sel, 2);
        frame(0, 0, 0, 0);
        chk("coinc_no_reblank", blank, 0);
        chk("coinc_sel_hold", pattern_sel, 2);
        chk("prst_count_coinc", rst_pulses, 5);

        // 6: async reset mid-blank
        for (int k = 0; k < 4; k++) frame(0, 0, 0, 0);
        repeat (10) @(negedge clk);
        chk("pre_rst_blank", blank, 1);
        chk("pre_rst_sel", pattern_sel, 2);
        chk("pre_rst_step", step_size, 4);
        rst = 1'b1;
        #1;
        chk("async_blank", blank, 0);
        chk("async_sel", pattern_sel, 0);
        chk("async_step", step_size, 1);
        chk("async_nf", next_frame, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frame(0, 0, 0, 0);
        chk("post_rst_blank", blank, 0);
        chk("post_rst_sel", pattern_sel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
